regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, register count; AW = clog2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 reads 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port ra, input, NRD*AW, packed read addresses, port k at bits [k*AW +: AW].
REQ-008 SHALL have port rv, input, NRD, read-valid per port (used only for stall).
REQ-009 SHALL have port rd, output, NRD*DW, packed read data, port k at bits [k*DW +: DW].
REQ-010 SHALL have ports we0, input, 1; wa0, input, AW; wd0, input, DW: write port 0, low priority.
REQ-011 SHALL have ports we1, input, 1; wa1, input, AW; wd1, input, DW: write port 1, high priority.
REQ-012 SHALL have ports iss_en, input, 1; iss_addr, input, AW: issue, marks destination pending.
REQ-013 SHALL have port stall, output, 1, read-after-write hazard on any valid read port.
REQ-014 SHALL have port pend_cnt, output, AW+1, number of pending registers.

Function
REQ-015 SHALL write wdN into register waN at posedge when weN=1 and waN in range (< DEPTH).
REQ-016 SHALL, when we0=we1=1 and wa0=wa1, store wd1 only.
REQ-017 SHALL drop writes to address 0 when ZERO_REG=1; rd for address 0 is 0.
REQ-018 SHALL drive rd combinationally; read with address >= DEPTH returns 0.
REQ-019 SHALL bypass same-cycle writes: rd for port k = wd1 if we1 and wa1 match, else wd0 if we0 and wa0 match, else stored value (ZERO_REG rule still applies).
REQ-020 SHALL hold one pending bit per register; iss_en=1 sets pending[iss_addr] at posedge.
REQ-021 SHALL clear pending[waN] at posedge for each active write port.
REQ-022 SHALL, on simultaneous set and clear of the same register, leave it set (issue wins).
REQ-023 SHALL never set pending for address 0 when ZERO_REG=1, nor for addresses >= DEPTH.
REQ-024 SHALL assert stall combinationally when any port k has rv[k]=1, pending[ra_k]=1, and no active write port targets ra_k this cycle.
REQ-025 SHALL keep stall deasserted for ports with rv[k]=0.
REQ-026 SHALL update pend_cnt registered, equal to popcount of pending after each edge; range 0..DEPTH.
REQ-027 SHALL support any NRD >= 1 and DEPTH >= 2 without RTL change.

Reset
REQ-028 SHALL, while rst=1 at posedge, clear all registers to 0, clear all pending bits, set pend_cnt to 0; writes and issues that cycle are ignored.
REQ-029 SHALL, after reset, present rd = 0 for every address and stall = 0.
REQ-030 SHALL reset mid-operation with outstanding pending bits to the same state as REQ-028.

Verification
REQ-031 SHALL cover: we0=1 wa0=5 wd0=0x1234, next cycle ra port0=5 -> rd0=0x1234; write wa0=0 wd0=0xFFFF -> rd for 0 stays 0.
REQ-032 SHALL cover: we0=1 wa0=7 wd0=0xAAAA and we1=1 wa1=7 wd1=0x5555 same cycle, ra port1=7 -> rd1=0x5555 same cycle and after edge.
REQ-033 SHALL cover: iss_en=1 iss_addr=3, next cycle rv0=1 ra0=3 -> stall=1, pend_cnt=1; then we1=1 wa1=3 wd1=0x42 -> stall=0 same cycle, rd0=0x42, pend_cnt=0 after edge.
REQ-034 SHALL cover: pending[9] clear, iss_en=1 iss_addr=9 with we0=1 wa0=9 same cycle -> pending[9]=1 after edge, register 9 holds wd0.
REQ-035 SHALL cover: issue to registers 1..4, then rst=1 one cycle -> pend_cnt=0, stall=0 for all addresses, all rd=0.
REQ-036 SHALL cover: NRD=3, DEPTH=16 build, ra=16-wide patterns with address 15 written -> rd correct on all three ports, pend_cnt saturates at 15 with ZERO_REG=1.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read, dual-write register file with a scoreboard.
//
// Read ports are combinational and forward same-cycle writes, so a consumer
// never has to wait on a register that is being written in the same cycle.
// Each register has a pending bit. Issuing an instruction sets the bit for its
// destination, and any write to that register clears it. A read of a pending
// register raises stall unless a write to that register is arriving in the
// same cycle.
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        synchronous active-high reset
//   ra         packed read addresses, port k at [k*AW +: AW]
//   rv         read-valid per port; affects only stall
//   rd         packed read data, port k at [k*DW +: DW]
//   we0/wa0/wd0  write port 0 (low priority)
//   we1/wa1/wd1  write port 1 (high priority)
//   iss_en/iss_addr  issue; marks destination pending
//   stall      RAW hazard on any valid read port
//   pend_cnt   registered count of pending registers

module regfile_sb #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    input  logic [NRD-1:0]    rv,
    output logic [NRD*DW-1:0] rd,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              stall,
    output logic [AW:0]       pend_cnt
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // DEPTH need not be a power of two, so some encodable addresses are
    // out of range.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [DW-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [AW:0]      cnt_nxt;

    logic wr0_act, wr1_act;
    logic wr0_st, wr1_st;
    logic iss_act;

    // Any in-range write clears the pending bit. Only writes that are not
    // aimed at the hardwired zero register change the stored data.
    assign wr0_act = we0 && in_range(wa0);
    assign wr1_act = we1 && in_range(wa1);
    assign wr0_st  = wr0_act && !is_zero(wa0);
    assign wr1_st  = wr1_act && !is_zero(wa1);
    assign iss_act = iss_en && in_range(iss_addr) && !is_zero(iss_addr);

    // Clears are applied first and the set is applied last. This lets an
    // issue win when it targets the same register as a write in that cycle.
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr0_act && (wa0 == AW'(i)))
                pend_nxt[i] = 1'b0;
            if (wr1_act && (wa1 == AW'(i)))
                pend_nxt[i] = 1'b0;
            if (iss_act && (iss_addr == AW'(i)))
                pend_nxt[i] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
    end

    // Port 1 is assigned last, so it takes priority on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr0_st)
                mem[wa0] <= wd0;
            if (wr1_st)
                mem[wa1] <= wd1;
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    logic [NRD-1:0] stall_k;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;
        logic          live;

        assign a    = ra[k*AW +: AW];
        assign hit0 = we0 && (wa0 == a);
        assign hit1 = we1 && (wa1 == a);
        assign live = in_range(a) && !is_zero(a);

        assign rd[k*DW +: DW] = !live ? '0  :
                                hit1  ? wd1 :
                                hit0  ? wd0 :
                                        mem[a];

        // A write landing this cycle is forwarded, so it resolves the hazard.
        assign stall_k[k] = rv[k] && in_range(a) && pend[a] && !hit0 && !hit1;
    end

    assign stall = |stall_k;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized bench for regfile_sb.
// dut_a: DW=32, DEPTH=16, NRD=3, ZERO_REG=1.
// dut_b: DW=16, DEPTH=12, NRD=1, ZERO_REG=0. Addresses 12..15 are out of range.
// Both instances share the stimulus. A reference model holds register contents
// and pending flags as plain arrays.

module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  ra [3];
    logic [2:0]  rv;
    logic        we0, we1, iss_en;
    logic [3:0]  wa0, wa1, iss_addr;
    logic [31:0] wd0, wd1;

    logic [11:0] a_ra;
    logic [95:0] a_rd;
    logic        a_stall;
    logic [4:0]  a_pc;
    logic [15:0] b_rd;
    logic        b_stall;
    logic [4:0]  b_pc;

    assign a_ra = {ra[2], ra[1], ra[0]};

    regfile_sb #(.DW(32), .DEPTH(16), .NRD(3), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .ra(a_ra), .rv(rv), .rd(a_rd),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .stall(a_stall), .pend_cnt(a_pc)
    );

    regfile_sb #(.DW(16), .DEPTH(12), .NRD(1), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .ra(ra[0]), .rv(rv[0]), .rd(b_rd),
        .we0(we0), .wa0(wa0), .wd0(wd0[15:0]),
        .we1(we1), .wa1(wa1), .wd1(wd1[15:0]),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .stall(b_stall), .pend_cnt(b_pc)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model ----------------
    logic [31:0] mmem  [2][16];
    bit          mpend [2][16];

    function automatic int dep(int i);
        return (i == 0) ? 16 : 12;
    endfunction

    function automatic bit zr(int i);
        return i == 0;
    endfunction

    function automatic logic [31:0] mask(int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] m_read(int i, int a);
        logic [31:0] v;
        if (a >= dep(i) || (zr(i) && a == 0))
            return 32'h0;
        if (we1 && int'(wa1) == a)      v = wd1;
        else if (we0 && int'(wa0) == a) v = wd0;
        else                            v = mmem[i][a];
        return v & mask(i);
    endfunction

    function automatic bit m_stall(int i, int n);
        bit s = 1'b0;
        for (int k = 0; k < n; k++) begin
            int a = int'(ra[k]);
            if (rv[k] && a < dep(i) && mpend[i][a] &&
                !(we0 && int'(wa0) == a) && !(we1 && int'(wa1) == a))
                s = 1'b1;
        end
        return s;
    endfunction

    function automatic int m_cnt(int i);
        int c = 0;
        for (int r = 0; r < 16; r++)
            if (mpend[i][r]) c++;
        return c;
    endfunction

    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int r = 0; r < 16; r++) begin
                    mmem[i][r]  = 32'h0;
                    mpend[i][r] = 1'b0;
                end
            end else begin
                int w0 = int'(wa0);
                int w1 = int'(wa1);
                int is = int'(iss_addr);
                if (we0 && w0 < dep(i) && !(zr(i) && w0 == 0)) mmem[i][w0] = wd0 & mask(i);
                if (we1 && w1 < dep(i) && !(zr(i) && w1 == 0)) mmem[i][w1] = wd1 & mask(i);
                if (we0 && w0 < dep(i)) mpend[i][w0] = 1'b0;
                if (we1 && w1 < dep(i)) mpend[i][w1] = 1'b0;
                if (iss_en && is < dep(i) && !(zr(i) && is == 0)) mpend[i][is] = 1'b1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Checks the combinational outputs mid-cycle, on the falling edge.
    task automatic mid();
        #4;
        for (int k = 0; k < 3; k++)
            chk($sformatf("a_rd%0d", k), a_rd[k*32 +: 32], m_read(0, int'(ra[k])));
        chk("a_stall", {31'b0, a_stall}, {31'b0, m_stall(0, 3)});
        chk("b_rd", {16'b0, b_rd}, m_read(1, int'(ra[0])));
        chk("b_stall", {31'b0, b_stall}, {31'b0, m_stall(1, 1)});
    endtask

    // Advances one clock edge, then checks the registered count.
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        chk("a_pend_cnt", 32'(a_pc), 32'(m_cnt(0)));
        chk("b_pend_cnt", 32'(b_pc), 32'(m_cnt(1)));
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; rv = 3'b000;
        wa0 = 4'd0; wa1 = 4'd0; wd0 = 32'h0; wd1 = 32'h0; iss_addr = 4'd0;
    endtask

    task automatic set_ra(logic [3:0] a);
        for (int k = 0; k < 3; k++) ra[k] = a;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        set_ra(4'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // After reset, every address reads 0 and nothing stalls.
        for (int a = 0; a < 16; a++) begin
            set_ra(4'(a));
            rv = 3'b111;
            mid();
            chk("rst_rd0", a_rd[31:0], 32'h0);
            chk("rst_stall", {31'b0, a_stall}, 32'h0);
            tick();
        end

        // Basic write/read, then a write to register 0.
        idle(); we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h1234;
        mid(); tick();
        idle(); ra[0] = 4'd5;
        mid();
        chk("w5_rd0", a_rd[31:0], 32'h1234);
        tick();
        idle(); we0 = 1'b1; wa0 = 4'd0; wd0 = 32'hFFFF; ra[0] = 4'd0;
        mid();
        chk("w0_rd0_same", a_rd[31:0], 32'h0);
        chk("b_w0_bypass", {16'b0, b_rd}, 32'h0000_FFFF);
        tick();
        idle();
        mid();
        chk("w0_rd0_after", a_rd[31:0], 32'h0);
        chk("b_w0_stored", {16'b0, b_rd}, 32'h0000_FFFF);
        tick();

        // Both write ports hit the same address. Port 1 wins.
        idle(); we0 = 1'b1; wa0 = 4'd7; wd0 = 32'hAAAA;
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h5555; ra[1] = 4'd7;
        mid();
        chk("coll_rd1_same", a_rd[63:32], 32'h5555);
        tick();
        idle();
        mid();
        chk("coll_rd1_after", a_rd[63:32], 32'h5555);
        tick();

        // A pending register stalls a valid read until a write arrives.
        idle(); iss_en = 1'b1; iss_addr = 4'd3;
        mid(); tick();
        idle(); rv[0] = 1'b1; ra[0] = 4'd3;
        mid();
        chk("haz_stall", {31'b0, a_stall}, 32'h1);
        chk("haz_cnt", 32'(a_pc), 32'd1);
        we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h42;
        mid();
        chk("haz_fwd_stall", {31'b0, a_stall}, 32'h0);
        chk("haz_fwd_rd0", a_rd[31:0], 32'h42);
        tick();
        chk("haz_cnt_clr", 32'(a_pc), 32'd0);

        // An issue and a write to the same register in one cycle. The issue wins.
        idle(); iss_en = 1'b1; iss_addr = 4'd9; we0 = 1'b1; wa0 = 4'd9; wd0 = 32'hBEEF;
        mid(); tick();
        idle(); rv[0] = 1'b1; ra[0] = 4'd9;
        mid();
        chk("iss_win_stall", {31'b0, a_stall}, 32'h1);
        chk("iss_win_rd0", a_rd[31:0], 32'hBEEF);
        chk("iss_win_cnt", 32'(a_pc), 32'd1);
        idle(); we1 = 1'b1; wa1 = 4'd9; wd1 = 32'h1;
        mid(); tick();

        // Reset in the middle of operation, with bits still pending.
        for (int r = 1; r <= 4; r++) begin
            idle(); iss_en = 1'b1; iss_addr = 4'(r);
            mid(); tick();
        end
        chk("pre_rst_cnt", 32'(a_pc), 32'd4);
        idle(); rst = 1'b1; iss_en = 1'b1; iss_addr = 4'd5;
        we0 = 1'b1; wa0 = 4'd6; wd0 = 32'h77;
        tick();
        idle();
        chk("mid_rst_cnt", 32'(a_pc), 32'd0);
        for (int a = 0; a < 16; a++) begin
            set_ra(4'(a));
            rv = 3'b111;
            mid();
            chk("mid_rst_rd2", a_rd[95:64], 32'h0);
            chk("mid_rst_stall", {31'b0, a_stall}, 32'h0);
            tick();
        end

        // Top address on all three ports, then the pending count saturates.
        idle(); we1 = 1'b1; wa1 = 4'd15; wd1 = 32'hCAFE_F00D;
        mid(); tick();
        idle(); set_ra(4'd15);
        mid();
        for (int k = 0; k < 3; k++)
            chk($sformatf("top_rd%0d", k), a_rd[k*32 +: 32], 32'hCAFE_F00D);
        ra[0] = 4'd14; ra[1] = 4'd15; ra[2] = 4'd5;
        mid();
        chk("mix_rd1", a_rd[63:32], 32'hCAFE_F00D);
        chk("mix_rd0", a_rd[31:0], 32'h0);
        tick();
        for (int r = 0; r < 16; r++) begin
            idle(); iss_en = 1'b1; iss_addr = 4'(r);
            mid(); tick();
        end
        chk("sat_cnt", 32'(a_pc), 32'd15);
        chk("b_sat_cnt", 32'(b_pc), 32'd12);
        idle(); iss_en = 1'b1; iss_addr = 4'd15;
        mid(); tick();
        chk("sat_cnt_hold", 32'(a_pc), 32'd15);

        // Randomized traffic, with addresses biased toward collisions.
        for (int n = 0; n < 500; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            we0      = $urandom_range(0, 1) == 1;
            we1      = $urandom_range(0, 2) == 0;
            iss_en   = $urandom_range(0, 2) != 0;
            wa0      = 4'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 15 : 3));
            wa1      = 4'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 15 : 3));
            iss_addr = 4'($urandom_range(0, 15));
            wd0      = $urandom;
            wd1      = $urandom;
            rv       = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++)
                ra[k] = 4'($urandom_range(0, ($urandom_range(0, 1) == 1) ? 15 : 3));
            mid();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
